// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding,
// oversample default and a constant clog2 helper used by TX and RX.
package uart_pkg;

    localparam int OVER_SAMP_DEF = 16;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud generator: divisor counter feeding an oversample counter. bit_end_o
// is high for the last clk cycle of each bit period; restart_i zeroes both.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int OVER_SAMP = OVER_SAMP_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_end_o,
    output logic             bit_end_nxt_o
);

    localparam int OS_W = (OVER_SAMP > 1) ? clog2(OVER_SAMP) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVER_SAMP - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic             bit_end_q;

    always_comb begin
        cnt_d = cnt_q;
        os_d  = os_q;
        if (restart_i) begin
            cnt_d = '0;
            os_d  = '0;
        end else if (cnt_q == div_i) begin
            cnt_d = '0;
            os_d  = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Look-ahead lets the parent register outputs that coincide with bit_end.
    assign bit_end_nxt_o = (cnt_d == div_i) && (os_d == OS_LAST);
    assign bit_end_o     = bit_end_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            os_q      <= '0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            os_q      <= os_d;
            bit_end_q <= bit_end_nxt_o;
        end
    end

endmodule

// File: rtl/uart_xmtr_cfg.sv
// Configurable UART transmitter with a one-word holding register in front
// of the shifter so frames can run back-to-back. Outputs are registered.
module uart_xmtr_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OVER_SAMP = OVER_SAMP_DEF,
    parameter int DIV_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [3:0]        cfg_len_i,
    input  logic [1:0]        cfg_par_i,
    input  logic              cfg_stop2_i,
    output logic              txd_o,
    output logic              busy_o,
    output logic              done_o
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic              hold_full_q, hold_full_d;
    logic              par_bit_q, par_bit_d;
    logic [3:0]        len_q, len_d, bit_cnt_q, bit_cnt_d;
    logic [1:0]        par_q, par_d;
    logic              stop2_q, stop2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              txd_q, txd_d, busy_q, busy_d, done_q, done_d;
    logic              bit_end, bit_end_nxt, load, last_stop;

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l < 4'd5) return 4'd5;
        if (l > 4'(DATA_W)) return 4'(DATA_W);
        return l;
    endfunction

    function automatic logic calc_par(input logic [DATA_W-1:0] d,
                                      input logic [3:0] len,
                                      input logic [1:0] mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(len)) x = x ^ d[i];
        end
        case (mode)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    uart_baud_tick #(.DIV_W(DIV_W), .OVER_SAMP(OVER_SAMP)) u_baud (
        .clk           (clk),
        .rstn          (rstn),
        .restart_i     (load),
        .div_i         (div_q),
        .bit_end_o     (bit_end),
        .bit_end_nxt_o (bit_end_nxt)
    );

    assign last_stop = (bit_cnt_q == {3'b000, stop2_q});
    // A load needs a full holding register, an accept needs an empty one.
    assign load = hold_full_q &&
                  ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end && last_stop));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        len_d       = len_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;

        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: ;
            ST_START: if (bit_end) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
            ST_DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == len_q - 4'd1) begin
                    bit_cnt_d = '0;
                    state_d   = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d   = ST_STOP;
                bit_cnt_d = '0;
            end
            ST_STOP: if (bit_end) begin
                if (last_stop) state_d = ST_IDLE;
                else           bit_cnt_d = bit_cnt_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            hold_full_d = 1'b0;
            shift_d     = hold_q;
            len_d       = clamp_len(cfg_len_i);
            par_d       = cfg_par_i;
            stop2_d     = cfg_stop2_i;
            div_d       = cfg_div_i;
            par_bit_d   = calc_par(hold_q, clamp_len(cfg_len_i), cfg_par_i);
            state_d     = ST_START;
            bit_cnt_d   = '0;
        end

        unique case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_bit_d;
            default:   txd_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && bit_end_nxt && (bit_cnt_d == {3'b000, stop2_d});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            len_q       <= 4'(DATA_W);
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            len_q       <= len_d;
            par_q       <= par_d;
            stop2_q     <= stop2_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready_o = !hold_full_q;
    assign txd_o      = txd_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_uart_xmtr_cfg.sv
// Directed bench for uart_xmtr_cfg: frames are checked bit by bit against
// hand-derived line levels, parity bits and cycle counts.
module tb_uart_xmtr_cfg;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [15:0] cfg_div_i = '0;
    logic [3:0]  cfg_len_i = 4'd8;
    logic [1:0]  cfg_par_i = PAR_NONE;
    logic        cfg_stop2_i = 1'b0;
    logic        txd_o, busy_o, done_o;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_mark;

    uart_xmtr_cfg dut (
        .clk         (clk),
        .rstn        (rstn),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .cfg_div_i   (cfg_div_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_par_i   (cfg_par_i),
        .cfg_stop2_i (cfg_stop2_i),
        .txd_o       (txd_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_o === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered in cycle 0; returns in cycle 2, the first start-bit cycle.
    task automatic send(input logic [7:0] d, input string tag);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        tick(1);
        tx_valid_i = 1'b0;
        chk({tag, "_rdy_c1"}, tx_ready_o, 1'b0);
        chk({tag, "_busy_c1"}, busy_o, 1'b0);
        chk({tag, "_txd_c1"}, txd_o, 1'b1);
        tick(1);
    endtask

    // Entered in the first start-bit cycle; returns in the cycle after the frame.
    task automatic check_frame(input logic [8:0] d, input int nd, input int pb,
                               input int ns, input int period, input logic exp_rdy,
                               input string tag);
        logic lv [0:15];
        int   nb;
        nb = 1 + nd + ((pb >= 0) ? 1 : 0) + ns;
        lv[0] = 1'b0;
        for (int i = 0; i < nd; i++) lv[1 + i] = d[i];
        if (pb >= 0) lv[1 + nd] = pb[0];
        for (int i = nb - ns; i < nb; i++) lv[i] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            chk($sformatf("%s_b%0d_txd_first", tag, b), txd_o, lv[b]);
            if (b == 0) chk($sformatf("%s_rdy_first", tag), tx_ready_o, 1'b1);
            tick(period - 1);
            if (b == 0) tx_valid_i = 1'b0;
            chk($sformatf("%s_b%0d_txd_last", tag, b), txd_o, lv[b]);
            chk($sformatf("%s_b%0d_busy", tag, b), busy_o, 1'b1);
            chk($sformatf("%s_b%0d_done", tag, b), done_o, (b == nb - 1) ? 1'b1 : 1'b0);
            chk($sformatf("%s_b%0d_rdy", tag, b), tx_ready_o, exp_rdy);
            tick(1);
        end
    endtask

    initial begin
        // Reset, then reset again while idle.
        tick(2);
        chk("rst_txd", txd_o, 1'b1);
        chk("rst_rdy", tx_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        rstn = 1'b1;
        tick(3);
        #2 rstn = 1'b0;
        #1;
        chk("idle_rst_txd", txd_o, 1'b1);
        chk("idle_rst_rdy", tx_ready_o, 1'b1);
        chk("idle_rst_busy", busy_o, 1'b0);
        chk("idle_rst_done", done_o, 1'b0);
        tick(1);
        rstn = 1'b1;
        tick(2);

        // 8N1, div 0, 0xA5: done in cycle 161, busy low in 162.
        send(8'hA5, "t2");
        check_frame(9'h0A5, 8, -1, 1, 16, 1'b1, "t2");
        chk("t2_busy_end", busy_o, 1'b0);
        chk("t2_done_end", done_o, 1'b0);
        chk("t2_txd_end", txd_o, 1'b1);

        // 7 data bits, two stops, even then odd parity; 176-cycle frames.
        cfg_len_i = 4'd7; cfg_par_i = PAR_EVEN; cfg_stop2_i = 1'b1;
        send(8'h03, "t3e");
        check_frame(9'h003, 7, 0, 2, 16, 1'b1, "t3e");
        chk("t3e_busy_end", busy_o, 1'b0);
        cfg_par_i = PAR_ODD;
        send(8'h83, "t3o");
        check_frame(9'h003, 7, 1, 2, 16, 1'b1, "t3o");
        chk("t3o_busy_end", busy_o, 1'b0);

        // Length clamps: 3 acts as 5, 12 acts as 8.
        cfg_len_i = 4'd3; cfg_par_i = PAR_EVEN; cfg_stop2_i = 1'b0;
        send(8'h35, "t3lo");
        check_frame(9'h015, 5, 1, 1, 16, 1'b1, "t3lo");
        chk("t3lo_busy_end", busy_o, 1'b0);
        cfg_len_i = 4'd12; cfg_par_i = PAR_ODD;
        send(8'h96, "t3hi");
        check_frame(9'h096, 8, 1, 1, 16, 1'b1, "t3hi");
        chk("t3hi_busy_end", busy_o, 1'b0);

        // Back-to-back: three words offered continuously.
        cfg_len_i = 4'd8; cfg_par_i = PAR_NONE;
        done_mark = done_cnt;
        tx_data_i = 8'h5A; tx_valid_i = 1'b1;
        tick(1);
        chk("t4_rdy_c1", tx_ready_o, 1'b0);
        tx_data_i = 8'hC3;
        tick(1);
        check_frame(9'h05A, 8, -1, 1, 16, 1'b0, "t4w1");
        tx_data_i = 8'h81; tx_valid_i = 1'b1;
        check_frame(9'h0C3, 8, -1, 1, 16, 1'b0, "t4w2");
        check_frame(9'h081, 8, -1, 1, 16, 1'b1, "t4w3");
        chk("t4_busy_end", busy_o, 1'b0);
        chk("t4_done_count", done_cnt - done_mark, 3);

        // Divisor 2 (48-cycle bits); mid-frame cfg change applies to next frame.
        cfg_div_i = 16'd2;
        send(8'h3C, "t5a");
        cfg_div_i = 16'd0; cfg_par_i = PAR_MARK;
        tx_data_i = 8'h0F; tx_valid_i = 1'b1;
        check_frame(9'h03C, 8, -1, 1, 48, 1'b0, "t5a");
        check_frame(9'h00F, 8, 1, 1, 16, 1'b1, "t5b");
        chk("t5_busy_end", busy_o, 1'b0);

        // Reset during data bit 3 with a word held: both are dropped.
        cfg_par_i = PAR_NONE;
        done_mark = done_cnt;
        send(8'hF0, "t6");
        tx_data_i = 8'h55; tx_valid_i = 1'b1;
        tick(1);
        tx_valid_i = 1'b0;
        chk("t6_rdy_held", tx_ready_o, 1'b0);
        tick(69);
        chk("t6_txd_bit3", txd_o, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("t6_txd_async", txd_o, 1'b1);
        chk("t6_busy_async", busy_o, 1'b0);
        chk("t6_rdy_async", tx_ready_o, 1'b1);
        chk("t6_done_async", done_o, 1'b0);
        tick(2);
        rstn = 1'b1;
        tick(40);
        chk("t6_busy_after", busy_o, 1'b0);
        chk("t6_txd_after", txd_o, 1'b1);
        chk("t6_no_done", done_cnt - done_mark, 0);
        send(8'h3A, "t6n");
        check_frame(9'h03A, 8, -1, 1, 16, 1'b1, "t6n");
        chk("t6n_busy_end", busy_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_xmtr_cfg.md
# uart_xmtr_cfg

Second-generation UART transmitter with runtime-configurable baud divisor, word length, parity and stop bits. Adds a valid/ready input handshake with a one-word holding register, so frames can go out back-to-back with no idle gap. It sits between a bus-side producer and the serial `txd` pin, and replaces the fixed 8N1 transmitter in new designs.

## Interface
- `DATA_W`, 8: maximum data bits per frame; legal range 5..9.
- `OVER_SAMP`, 16: baud ticks per bit period.
- `DIV_W`, 16: width of the baud divisor.
- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `tx_data_i` input DATA_W: word to send, LSB first.
- `tx_valid_i` input 1: `tx_data_i` is valid.
- `tx_ready_o` output 1: holding register can accept a word.
- `cfg_div_i` input DIV_W: one baud tick every `cfg_div_i+1` clk cycles.
- `cfg_len_i` input 4: number of data bits.
- `cfg_par_i` input 2: parity mode. 00 none, 01 even, 10 odd, 11 mark (constant 1).
- `cfg_stop2_i` input 1: 0 gives one stop bit, 1 gives two.
- `txd_o` output 1: serial line, idle high.
- `busy_o` output 1: a frame is in progress.
- `done_o` output 1: one-cycle pulse when a frame's last stop bit ends.

## Operation
- **Handshake.** A word transfers on a rising edge where `tx_valid_i & tx_ready_o`. `tx_ready_o = !hold_full`.
- **Holding register.** Holds one word. It moves into the shifter when the FSM is in IDLE, or at the end of the last stop bit. On the cycle it moves, `tx_ready_o` is 0, so there is never a simultaneous accept and load.
- **Config sampling.** `cfg_*` is latched at frame load. Changes during a frame take effect on the next frame only.
- **Word-length clamp.** `cfg_len_i` below 5 is treated as 5. Values above `DATA_W` are treated as `DATA_W`. Data bits above the effective length are ignored.
- **Parity.** Computed over the effective-length LSBs.
  - Even: the data bits plus the parity bit have an even number of 1s.
  - Odd: the data bits plus the parity bit have an odd number of 1s.
- **FSM** (IDLE, START, DATA, PARITY, STOP):
  - IDLE→START when the holding register is full.
  - START→DATA at bit end.
  - DATA: one bit per period. After the last data bit, go to PARITY if parity is enabled, else STOP.
  - PARITY→STOP at bit end.
  - STOP lasts 1 or 2 bit periods. At its end, go to START if the holding register is full, else IDLE.
- **`txd_o` per state.** IDLE 1, START 0, DATA shifter LSB, PARITY computed bit, STOP 1.
- **Baud counter.** Restarts at every frame load, so the first bit is full length. Bit period = `(div+1)*OVER_SAMP` clk cycles.
- **Frame length.** `(div+1)*OVER_SAMP*(1+len+p+s)` clk cycles, where p ∈ {0,1} and s ∈ {1,2}.
- **`busy_o`** is high whenever the FSM is not in IDLE.
- **`done_o`** pulses in the final clk cycle of the last stop bit.

## Timing
- **Reset values.** `txd_o`=1, `tx_ready_o`=1, `busy_o`=0, `done_o`=0. Holding register empty, FSM in IDLE, counters 0.
- **Reset mid-frame.** `txd_o` goes high asynchronously. No `done_o` pulse. The partial frame is lost, including any held word.
- **Latency from idle.** Handshake edge at end of cycle 0 → `hold_full` in cycle 1 → `txd_o`=0 and `busy_o`=1 from cycle 2. `tx_ready_o` is 0 in cycle 1 and 1 again in cycle 2.
- **Back-to-back frames.** If a word is held at stop end, the next start bit begins in the cycle immediately after the last stop cycle. There is zero idle time.
- **Registered outputs.** All outputs are registered; there is no combinational path from inputs to outputs.
- **Divisor 0** is legal: one tick per clk cycle.

## Structure
- **Package `uart_pkg`:**
  - parity mode constants: `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`, `PAR_MARK`;
  - FSM state encoding;
  - `OVER_SAMP` default;
  - a `clog2` function, shared with the receiver.
- **Sub-module `uart_baud_tick`.** Contains the divisor counter plus the oversample counter. Has a `restart` input and emits a `bit_end` pulse. The top level holds the holding register, shifter, parity and FSM.

## Test plan
1. **Reset.** Assert `rstn` low mid-idle → `txd_o`=1, `tx_ready_o`=1, `busy_o`=0, `done_o`=0.
2. **8N1, div=0, 0xA5.** Handshake in cycle 0 → `txd_o`=0 for cycles 2–17, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then stop high → `done_o` pulses in cycle 161 and `busy_o` falls in cycle 162.
3. **7-bit data 0x03, two stop bits.**
   - Even parity → parity bit 0.
   - Odd parity → parity bit 1.
   - Frame length is 176 cycles (11 bits at div=0).
   - `cfg_len_i`=3 behaves as 5; `cfg_len_i`=12 behaves as `DATA_W`.
4. **Back-to-back, three words offered continuously.**
   - Word 2 is accepted in cycle 2.
   - `tx_ready_o` stays 0 until word 2 is loaded.
   - Word 2's start bit begins in the cycle after word 1's last stop cycle.
   - Word 3 is then accepted.
   - `done_o` pulses once per frame.
5. **Divisor.** div=2 → bit period 48 cycles. Changing `cfg_div_i` and `cfg_par_i` mid-frame leaves the current frame unchanged; the next frame uses the new values.
6. **Reset mid-data bit.** Drop `rstn` during bit 3 → `txd_o` is 1 immediately, there is no `done_o`, and after release a new word transmits normally.
